// File: rtl/pc_cache_engine_if.sv
// pc_cache_engine_if
// Groups the ALU, memory, PC and save-stream signals of pc_cache_engine.
//   master : the surrounding datapath (drives requests, reads results)
//   slave  : the engine itself
// Request side : alu_out, cache_write, cache_sel, pc, mem_out, mem_valid,
//                load_start, save_start, save_ready
// Result side  : cache_out, load_out, load_done, save_out, save_valid, busy
interface pc_cache_engine_if #(
    parameter int DATA_W      = 8,
    parameter int PC_BYTES    = 2,
    parameter int CACHE_DEPTH = 4
);
    localparam int PC_W   = DATA_W * PC_BYTES;
    localparam int CSEL_W = (CACHE_DEPTH > 1) ? $clog2(CACHE_DEPTH) : 1;

    logic [DATA_W-1:0] alu_out;
    logic              cache_write;
    logic [CSEL_W-1:0] cache_sel;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] mem_out;
    logic              mem_valid;
    logic              load_start;
    logic              save_start;
    logic              save_ready;
    logic [DATA_W-1:0] cache_out;
    logic [PC_W-1:0]   load_out;
    logic              load_done;
    logic [DATA_W-1:0] save_out;
    logic              save_valid;
    logic              busy;

    modport master (
        output alu_out, cache_write, cache_sel, pc, mem_out, mem_valid,
               load_start, save_start, save_ready,
        input  cache_out, load_out, load_done, save_out, save_valid, busy
    );

    modport slave (
        input  alu_out, cache_write, cache_sel, pc, mem_out, mem_valid,
               load_start, save_start, save_ready,
        output cache_out, load_out, load_done, save_out, save_valid, busy
    );
endinterface

// File: rtl/pc_cache_engine.sv
// pc_cache_engine
// Small bank of ALU-written cache bytes plus a PC snapshot taken on every
// cache write. A byte-serial loader assembles a jump target from memory
// (LS byte first); a byte-serial saver streams the snapshot out (MS byte
// first) under a valid/ready handshake.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : pc_cache_engine_if.slave (see interface for signal list)
module pc_cache_engine #(
    parameter int DATA_W      = 8,
    parameter int PC_BYTES    = 2,
    parameter int CACHE_DEPTH = 4,
    parameter int CACHE_INIT  = 212
) (
    input  logic                clk,
    input  logic                reset,
    pc_cache_engine_if.slave    bus
);
    localparam int PC_W   = DATA_W * PC_BYTES;
    localparam int CSEL_W = (CACHE_DEPTH > 1) ? $clog2(CACHE_DEPTH) : 1;
    localparam int CNT_W  = (PC_BYTES > 1) ? $clog2(PC_BYTES) : 1;

    localparam logic [CNT_W-1:0]  LAST_C    = CNT_W'(PC_BYTES - 1);
    localparam logic [CNT_W-1:0]  ZERO_C    = {CNT_W{1'b0}};
    localparam logic [CSEL_W:0]   DEPTH_C   = (CSEL_W + 1)'(CACHE_DEPTH);
    localparam logic [DATA_W-1:0] INIT_C    = DATA_W'(CACHE_INIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SAVE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [DATA_W-1:0]  cache_mem_r [CACHE_DEPTH];
    logic [PC_W-1:0]    snapshot_r;
    logic [PC_W-1:0]    shift_r;
    logic [PC_W-1:0]    asm_r;
    logic [PC_W-1:0]    asm_next_s;
    logic [PC_W-1:0]    load_out_r;
    logic               load_done_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               sel_ok_s;
    logic [DATA_W-1:0]  save_byte_s;
    logic [DATA_W-1:0]  save_out_s;
    logic               save_valid_s;
    logic               busy_s;

    // Range check of the shared cache index (one extra bit avoids wrap).
    always_comb begin
        sel_ok_s = ({1'b0, bus.cache_sel} < DEPTH_C);
    end

    // Assembly value with the incoming memory byte merged at the counter slot.
    always_comb begin
        asm_next_s = asm_r;
        for (int i = 0; i < PC_BYTES; i++) begin
            if (cnt_r == CNT_W'(i)) begin
                asm_next_s[i*DATA_W +: DATA_W] = bus.mem_out;
            end else begin
                asm_next_s[i*DATA_W +: DATA_W] = asm_r[i*DATA_W +: DATA_W];
            end
        end
    end

    // Byte of the in-flight shift register selected by the counter.
    always_comb begin
        save_byte_s = {DATA_W{1'b0}};
        for (int i = 0; i < PC_BYTES; i++) begin
            if (cnt_r == CNT_W'(i)) begin
                save_byte_s = shift_r[i*DATA_W +: DATA_W];
            end else begin
                save_byte_s = save_byte_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; load wins a simultaneous start.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.load_start) begin
                    state_next_s = ST_LOAD;
                end else if (bus.save_start) begin
                    state_next_s = ST_SAVE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (bus.mem_valid && (cnt_r == LAST_C)) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_SAVE: begin
                if (bus.save_ready && (cnt_r == ZERO_C)) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SAVE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode: save stream is live only while saving.
    always_comb begin
        save_out_s   = {DATA_W{1'b0}};
        save_valid_s = 1'b0;
        busy_s       = 1'b1;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_LOAD: begin
                busy_s = 1'b1;
            end
            ST_SAVE: begin
                save_out_s   = save_byte_s;
                save_valid_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Cache bank and snapshot; writes are accepted in every state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CACHE_DEPTH; i++) begin
                cache_mem_r[i] <= (i == 0) ? INIT_C : {DATA_W{1'b0}};
            end
            snapshot_r <= {PC_W{1'b0}};
        end else if (bus.cache_write) begin
            if (sel_ok_s) begin
                cache_mem_r[bus.cache_sel] <= bus.alu_out;
            end
            snapshot_r <= bus.pc;
        end
    end

    // Loader/saver datapath: byte counter, assembly and shift registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r       <= ZERO_C;
            asm_r       <= {PC_W{1'b0}};
            shift_r     <= {PC_W{1'b0}};
            load_out_r  <= {PC_W{1'b0}};
            load_done_r <= 1'b0;
        end else begin
            load_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.load_start) begin
                        cnt_r <= ZERO_C;
                    end else if (bus.save_start) begin
                        shift_r <= snapshot_r;
                        cnt_r   <= LAST_C;
                    end
                end
                ST_LOAD: begin
                    if (bus.mem_valid) begin
                        asm_r <= asm_next_s;
                        if (cnt_r == LAST_C) begin
                            load_out_r  <= asm_next_s;
                            load_done_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end
                end
                ST_SAVE: begin
                    if (bus.save_ready && (cnt_r != ZERO_C)) begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                default: begin
                    cnt_r <= ZERO_C;
                end
            endcase
        end
    end

    assign bus.cache_out  = sel_ok_s ? cache_mem_r[bus.cache_sel] : {DATA_W{1'b0}};
    assign bus.load_out   = load_out_r;
    assign bus.load_done  = load_done_r;
    assign bus.save_out   = save_out_s;
    assign bus.save_valid = save_valid_s;
    assign bus.busy       = busy_s;
endmodule

// File: tb/tb_pc_cache_engine.sv
module tb_pc_cache_engine;
    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    pc_cache_engine_if #(.DATA_W(8), .PC_BYTES(2), .CACHE_DEPTH(4)) bus ();

    pc_cache_engine #(
        .DATA_W(8), .PC_BYTES(2), .CACHE_DEPTH(4), .CACHE_INIT(212)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset           = 1'b0;
        bus.alu_out     = 8'h00;
        bus.cache_write = 1'b0;
        bus.cache_sel   = 2'd0;
        bus.pc          = 16'h0000;
        bus.mem_out     = 8'h00;
        bus.mem_valid   = 1'b0;
        bus.load_start  = 1'b0;
        bus.save_start  = 1'b0;
        bus.save_ready  = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;

        // Reset state
        bus.cache_sel = 2'd0; #1; check("rst_cache0", bus.cache_out, 32'd212);
        bus.cache_sel = 2'd1; #1; check("rst_cache1", bus.cache_out, 32'd0);
        bus.cache_sel = 2'd2; #1; check("rst_cache2", bus.cache_out, 32'd0);
        bus.cache_sel = 2'd3; #1; check("rst_cache3", bus.cache_out, 32'd0);
        check("rst_load_out", bus.load_out, 32'h0);
        check("rst_load_done", bus.load_done, 32'h0);
        check("rst_busy", bus.busy, 32'h0);
        check("rst_save_valid", bus.save_valid, 32'h0);
        check("rst_save_out", bus.save_out, 32'h0);

        // Cache write then save of the snapshot 0x1234
        step();
        bus.cache_sel = 2'd2; bus.alu_out = 8'h5A; bus.pc = 16'h1234; bus.cache_write = 1'b1;
        step();
        bus.cache_write = 1'b0; #1;
        check("wr_cache2", bus.cache_out, 32'h5A);
        bus.cache_sel = 2'd0; #1;
        check("wr_cache0_kept", bus.cache_out, 32'd212);
        bus.save_start = 1'b1; bus.save_ready = 1'b1;
        step();
        bus.save_start = 1'b0; #1;
        check("sv1_valid", bus.save_valid, 32'h1);
        check("sv1_byte_hi", bus.save_out, 32'h12);
        check("sv1_busy", bus.busy, 32'h1);
        step();
        check("sv1_byte_lo", bus.save_out, 32'h34);
        check("sv1_valid_lo", bus.save_valid, 32'h1);
        step();
        check("sv1_end_valid", bus.save_valid, 32'h0);
        check("sv1_end_out", bus.save_out, 32'h0);
        check("sv1_end_busy", bus.busy, 32'h0);
        bus.save_ready = 1'b0;

        // Load with a stall cycle: 0xCD, gap, 0xAB -> 0xABCD
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0; bus.mem_out = 8'hCD; bus.mem_valid = 1'b1;
        check("ld_busy_start", bus.busy, 32'h1);
        step();
        bus.mem_valid = 1'b0; bus.mem_out = 8'hFF;
        check("ld_done_early", bus.load_done, 32'h0);
        step();
        check("ld_stall_busy", bus.busy, 32'h1);
        check("ld_stall_done", bus.load_done, 32'h0);
        check("ld_stall_out", bus.load_out, 32'h0);
        bus.mem_out = 8'hAB; bus.mem_valid = 1'b1;
        step();
        bus.mem_valid = 1'b0;
        check("ld_out", bus.load_out, 32'hABCD);
        check("ld_done_pulse", bus.load_done, 32'h1);
        check("ld_busy_fall", bus.busy, 32'h0);
        step();
        check("ld_done_clear", bus.load_done, 32'h0);
        check("ld_out_hold", bus.load_out, 32'hABCD);

        // Save backpressure on snapshot 0xBEEF, with a write mid-save
        bus.cache_sel = 2'd3; bus.alu_out = 8'h77; bus.pc = 16'hBEEF; bus.cache_write = 1'b1;
        step();
        bus.cache_write = 1'b0; bus.save_ready = 1'b0; bus.save_start = 1'b1;
        step();
        bus.save_start = 1'b0;
        check("bp_valid0", bus.save_valid, 32'h1);
        check("bp_out0", bus.save_out, 32'hBE);
        bus.cache_sel = 2'd1; bus.alu_out = 8'h42; bus.pc = 16'hA55A; bus.cache_write = 1'b1;
        step();
        bus.cache_write = 1'b0;
        check("bp_out1", bus.save_out, 32'hBE);
        step();
        check("bp_out2", bus.save_out, 32'hBE);
        check("bp_valid2", bus.save_valid, 32'h1);
        #1;
        check("bp_cache1", bus.cache_out, 32'h42);
        bus.save_ready = 1'b1;
        step();
        check("bp_out_lo", bus.save_out, 32'hEF);
        check("bp_valid_lo", bus.save_valid, 32'h1);
        step();
        check("bp_idle", bus.save_valid, 32'h0);
        check("bp_idle_busy", bus.busy, 32'h0);
        bus.save_ready = 1'b0;

        // Start collision: load wins; save_start during LOAD is ignored
        bus.load_start = 1'b1; bus.save_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        check("col_busy", bus.busy, 32'h1);
        check("col_no_save", bus.save_valid, 32'h0);
        step();
        bus.save_start = 1'b0;
        check("col_ignore_save", bus.save_valid, 32'h0);
        bus.mem_out = 8'h11; bus.mem_valid = 1'b1;
        step();
        bus.mem_out = 8'h22;
        step();
        bus.mem_valid = 1'b0;
        check("col_load_out", bus.load_out, 32'h2211);
        check("col_load_done", bus.load_done, 32'h1);
        check("col_save_valid", bus.save_valid, 32'h0);
        step();
        check("col_idle", bus.busy, 32'h0);

        // Async reset mid-save after the first byte (snapshot 0xA55A)
        bus.save_start = 1'b1; bus.save_ready = 1'b1;
        step();
        bus.save_start = 1'b0;
        check("ar_hi", bus.save_out, 32'hA5);
        step();
        bus.save_ready = 1'b0;
        check("ar_lo", bus.save_out, 32'h5A);
        #2;
        reset = 1'b0;
        #1;
        check("ar_valid", bus.save_valid, 32'h0);
        check("ar_busy", bus.busy, 32'h0);
        check("ar_load_out", bus.load_out, 32'h0);
        check("ar_cache1", bus.cache_out, 32'h0);
        bus.cache_sel = 2'd0; #0.5;
        check("ar_cache0", bus.cache_out, 32'd212);
        reset = 1'b1;
        step();
        bus.save_start = 1'b1;
        step();
        bus.save_start = 1'b0;
        check("ar_resave_valid", bus.save_valid, 32'h1);
        check("ar_resave_hi", bus.save_out, 32'h00);
        bus.save_ready = 1'b1;
        step();
        check("ar_resave_lo", bus.save_out, 32'h00);
        check("ar_resave_valid2", bus.save_valid, 32'h1);
        step();
        check("ar_resave_idle", bus.busy, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/pc_cache_engine.md
Name: pc_cache_engine

Overview:
Parametrised successor to the processor's single-byte cache/loader logic. Holds a small bank of ALU-written cache bytes and snapshots the full program counter on every cache write. A byte-serial loader FSM assembles a multi-byte jump target from memory. A byte-serial saver FSM streams the PC snapshot out to memory under a valid/ready handshake. It sits between the ALU, the memory data path and the PC/branch logic.

Parameters:
DATA_W, 8, width of one memory/ALU byte
PC_BYTES, 2, number of DATA_W bytes in a program counter (must be >= 1); PC_W = DATA_W*PC_BYTES
CACHE_DEPTH, 4, number of cache entries (must be >= 1); CSEL_W = max(1, clog2(CACHE_DEPTH))
CACHE_INIT, 212, reset value of cache entry 0

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
alu_out  in  DATA_W  write data for the cache bank
cache_write  in  1  write strobe: store alu_out and snapshot pc
cache_sel  in  CSEL_W  cache entry index for both read and write
pc  in  PC_W  current program counter
mem_out  in  DATA_W  memory read byte for the loader
mem_valid  in  1  mem_out carries a valid byte this cycle
load_start  in  1  request to begin assembling a PC from memory
save_start  in  1  request to begin streaming the PC snapshot
save_ready  in  1  consumer accepts save_out this cycle
cache_out  out  DATA_W  entry[cache_sel], combinational read
load_out  out  PC_W  last completed assembled PC
load_done  out  1  one-cycle pulse: load_out has just been updated
save_out  out  DATA_W  current snapshot byte being streamed
save_valid  out  1  save_out is valid
busy  out  1  FSM is not IDLE

Behaviour:
- Reset (reset low, asynchronous) clears the block immediately:
  - entry[0] = CACHE_INIT; all other entries = 0.
  - snapshot, save shift register, assembly register and load_out = 0.
  - load_done = 0, save_valid = 0, busy = 0, byte counter = 0, FSM = IDLE.
  - Reset mid-load or mid-save abandons the operation; no load_done is produced.
- Cache bank:
  - A rising edge with cache_write=1 sets entry[cache_sel] <= alu_out and snapshot <= pc.
  - Writes are allowed in every FSM state.
  - cache_out is a combinational read, so the new value is visible the cycle after the write.
  - When cache_sel >= CACHE_DEPTH, reads return 0, writes to the bank are ignored, and the snapshot still updates.
- FSM states: IDLE, LOAD, SAVE.
  - IDLE + load_start -> LOAD; counter = 0.
  - IDLE + save_start + !load_start -> SAVE; shift register <= snapshot; counter = PC_BYTES-1.
  - If load_start and save_start are both high in IDLE, load wins and the save request is dropped.
  - Starts received outside IDLE are ignored. No queuing.
- LOAD:
  - Each edge with mem_valid=1 writes mem_out into assembly byte[counter]. Least-significant byte first.
  - On the byte where counter == PC_BYTES-1: load_out <= full assembled value (including that byte), load_done = 1 for exactly the next cycle, and the FSM returns to IDLE.
  - Cycles with mem_valid=0 stall and leave state unchanged.
  - A new load can start on the cycle load_done is high.
- SAVE:
  - save_valid = 1 exactly while in SAVE.
  - save_out = shift byte[counter], so the most-significant byte goes first.
  - A transfer occurs when save_valid && save_ready; counter then decrements.
  - After the transfer at counter == 0 the FSM returns to IDLE.
  - save_out is held stable while save_ready = 0.
  - A cache_write during SAVE updates the snapshot but not the bytes already in flight.
- In IDLE, save_out = 0.
- busy = (state != IDLE).
- PC_BYTES = 1 means a single-byte load or save, with load_done the cycle after the byte is accepted.

Test Plan:
- Reset: release reset -> cache_out = 212 with sel=0 and 0 with sel=1..3; load_out = 0; busy = 0; save_valid = 0.
- Cache write: sel=2, alu_out=0x5A, pc=0x1234, write pulse -> cache_out = 0x5A next cycle; a following save streams 0x12 then 0x34.
- Load with stall: load_start; mem_out sequence 0xCD (valid), gap cycle (mem_valid=0), 0xAB (valid) -> load_out = 0xABCD with a single load_done pulse one cycle after 0xAB; busy falls at the same time.
- Save backpressure: snapshot 0xBEEF, save_ready held low 3 cycles -> save_out stays 0xBE with save_valid=1; raise ready -> 0xEF on the next cycle, then IDLE.
- Start collision/ignore: load_start and save_start high together in IDLE -> LOAD entered, no save_valid. save_start during LOAD -> ignored.
- Async reset mid-save after the first byte -> outputs return to reset values immediately with no clock edge; the next save restarts from the MS byte of the snapshot, which reset has cleared to 0.
